// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: command encoding and FSM state type shared by alu_seq, its
// multiplier and anything that drives cmd.
package alu_seq_pkg;

  localparam logic [3:0] CMD_ADD  = 4'd0;
  localparam logic [3:0] CMD_SUB  = 4'd1;
  localparam logic [3:0] CMD_XOR  = 4'd2;
  localparam logic [3:0] CMD_SLT  = 4'd3;
  localparam logic [3:0] CMD_AND  = 4'd4;
  localparam logic [3:0] CMD_NAND = 4'd5;
  localparam logic [3:0] CMD_OR   = 4'd6;
  localparam logic [3:0] CMD_NOR  = 4'd7;
  localparam logic [3:0] CMD_SLL  = 4'd8;
  localparam logic [3:0] CMD_SRL  = 4'd9;
  localparam logic [3:0] CMD_SRA  = 4'd10;
  localparam logic [3:0] CMD_MUL  = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } aluStateT;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: unsigned shift-add multiplier, one partial product per cycle.
// done is high during the cycle whose rising edge retires the last partial product.
module alu_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] productLo,
  output logic [WIDTH-1:0] productHi
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [CW-1:0]    count;
  logic             running;
  logic [WIDTH:0]   partial;

  // productLo starts as the multiplier and is shifted out as product bits shift in.
  assign partial = {1'b0, productHi} + (productLo[0] ? {1'b0, mcand} : '0);
  assign done    = running && (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      running   <= 1'b0;
      count     <= '0;
      mcand     <= '0;
      productLo <= '0;
      productHi <= '0;
    end else if (start) begin
      running   <= 1'b1;
      count     <= '0;
      mcand     <= a;
      productLo <= b;
      productHi <= '0;
    end else if (running) begin
      {productHi, productLo} <= {partial, productLo[WIDTH-1:1]};
      count                  <= count + CW'(1);
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: one-operation-at-a-time ALU with valid/ready handshakes on both sides.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier; otherwise MUL is an illegal cmd.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       cmd,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             err
);
  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH:0] ONE = 1;

  aluStateT         state;
  logic             accept, mulCmd, mulDone;
  logic [WIDTH:0]   addSum, subSum;
  logic             addOv, subOv;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] aluRes, resReg;
  logic             aluCarry, aluOv, aluErr;
  logic             carryReg, ovReg, zeroReg, errReg;

  assign in_ready  = (state == IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);

  assign addSum = {1'b0, a} + {1'b0, b};
  assign subSum = {1'b0, a} + {1'b0, ~b} + ONE;
  assign addOv  = (a[MSB] == b[MSB]) && (addSum[MSB] != a[MSB]);
  assign subOv  = (a[MSB] != b[MSB]) && (subSum[MSB] != a[MSB]);
  assign shamt  = b[SHW-1:0];

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    aluRes   = '0;
    aluCarry = 1'b0;
    aluOv    = 1'b0;
    aluErr   = 1'b0;
    case (cmd)
      CMD_ADD:  begin aluRes = addSum[MSB:0]; aluCarry = addSum[WIDTH]; aluOv = addOv; end
      CMD_SUB:  begin aluRes = subSum[MSB:0]; aluCarry = subSum[WIDTH]; aluOv = subOv; end
      CMD_XOR:  aluRes = a ^ b;
      CMD_SLT:  aluRes = {{(WIDTH-1){1'b0}}, subSum[MSB] ^ subOv};
      CMD_AND:  aluRes = a & b;
      CMD_NAND: aluRes = ~(a & b);
      CMD_OR:   aluRes = a | b;
      CMD_NOR:  aluRes = ~(a | b);
      CMD_SLL:  aluRes = a << shamt;
      CMD_SRL:  aluRes = a >> shamt;
      CMD_SRA:  aluRes = $unsigned($signed(a) >>> shamt);
      default:  aluErr = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic             mulSel;
  logic [WIDTH-1:0] mulLo, mulHi;

  assign mulCmd = (cmd == CMD_MUL);

  alu_seq_mul #(.WIDTH(WIDTH)) uMul (
    .clk       (clk),
    .reset     (reset),
    .start     (accept && mulCmd),
    .a         (a),
    .b         (b),
    .done      (mulDone),
    .productLo (mulLo),
    .productHi (mulHi)
  );

  always_ff @(posedge clk) begin
    if (reset)       mulSel <= 1'b0;
    else if (accept) mulSel <= mulCmd;
  end

  // The product stays registered inside the multiplier, so MUL results are read from it directly.
  assign result   = mulSel ? mulLo : resReg;
  assign overflow = mulSel ? (mulHi != '0) : ovReg;
  assign zero     = mulSel ? (mulLo == '0) : zeroReg;
`else
  assign mulCmd   = 1'b0;
  assign mulDone  = 1'b0;
  assign result   = resReg;
  assign overflow = ovReg;
  assign zero     = zeroReg;
`endif

  assign carryout = carryReg;
  assign err      = errReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: result and flag registers are cleared too, since reset must blank the visible outputs.
      state    <= IDLE;
      resReg   <= '0;
      carryReg <= 1'b0;
      ovReg    <= 1'b0;
      zeroReg  <= 1'b0;
      errReg   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: if (accept) begin
          state    <= mulCmd ? BUSY : DONE;
          resReg   <= aluRes;
          carryReg <= aluCarry;
          ovReg    <= aluOv;
          zeroReg  <= (aluRes == '0);
          errReg   <= aluErr && !mulCmd;
        end
        BUSY: if (mulDone) state <= DONE;
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq (WIDTH=32) against a
// behavioural model; follows ALU_SEQ_MUL_EN the same way the design does.
`timescale 1ns/1ps
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   cmd;
  logic [W-1:0] a, b, result;
  logic         carryout, overflow, zero, err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        carry;
    logic        ov;
    logic        zero;
    logic        err;
    logic [7:0]  lat;
  } outT;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .cmd(cmd), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carryout(carryout), .overflow(overflow), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic string fmt(input outT o);
    return $sformatf("res=%h c=%b v=%b z=%b e=%b lat=%0d", o.res, o.carry, o.ov, o.zero, o.err, o.lat);
  endfunction

  function automatic outT sample(input logic [7:0] lat);
    outT o;
    o = {result, carryout, overflow, zero, err, lat};
    return o;
  endfunction

  // Expected behaviour from plain integer arithmetic.
  function automatic outT model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    outT r;
    longint sx, sy, s;
    logic [63:0] ux, uy, p;
    logic [4:0] sh;
    r = '0;
    r.lat = 8'd1;
    sx = $signed(x);
    sy = $signed(y);
    ux = 64'(x);
    uy = 64'(y);
    sh = y[4:0];
    case (c)
      4'd0: begin
        r.res = x + y; r.carry = (ux + uy) >= 64'h1_0000_0000;
        s = sx + sy; r.ov = (s != longint'($signed(r.res)));
      end
      4'd1: begin
        r.res = x - y; r.carry = (x >= y);
        s = sx - sy; r.ov = (s != longint'($signed(r.res)));
      end
      4'd2:  r.res = x ^ y;
      4'd3:  r.res = (sx < sy) ? 32'd1 : 32'd0;
      4'd4:  r.res = x & y;
      4'd5:  r.res = ~(x & y);
      4'd6:  r.res = x | y;
      4'd7:  r.res = ~(x | y);
      4'd8:  r.res = x << sh;
      4'd9:  r.res = x >> sh;
      4'd10: r.res = $unsigned($signed(x) >>> sh);
`ifdef ALU_SEQ_MUL_EN
      4'd11: begin
        p = ux * uy; r.res = p[31:0]; r.ov = (p[63:32] != 0); r.lat = 8'(W + 1);
      end
`endif
      default: r.err = 1'b1;
    endcase
    r.zero = (r.res == 0);
    return r;
  endfunction

  // Drives one request, waits (bounded) for the result, samples it and releases it.
  task automatic doTransaction(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                               output outT got);
    int n;
    @(negedge clk);
    in_valid = 1'b1; cmd = c; a = x; b = y;
    @(negedge clk);
    in_valid = 1'b0; cmd = 4'($urandom); a = $urandom; b = $urandom;
    n = 1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    got = sample(out_valid ? 8'(n) : 8'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cmd = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, result, carryout, overflow, zero, err} !== '0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b %s, expected all zero",
               in_ready, out_valid, fmt(sample(8'd0)));
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b, expected 1", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [3:0]  vc [11];
    logic [31:0] vx [11];
    logic [31:0] vy [11];
    outT         ve [11];
    outT         got;
    vc = '{CMD_ADD, CMD_SUB, CMD_SLT, CMD_SRA, CMD_SRL, 4'd13, CMD_SLL, CMD_SRA, CMD_NAND, CMD_ADD, CMD_SUB};
    vx = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h1234,
           32'h1, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    vy = '{32'h1, 32'd5, 32'h1, 32'h21, 32'h21, 32'h5678,
           32'h3F, 32'h20, 32'hFFFFFFFF, 32'h1, 32'h1};
    ve[0]  = {32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
    ve[1]  = {32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
    ve[2]  = {32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    ve[3]  = {32'hC0000000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    ve[4]  = {32'h40000000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    ve[5]  = {32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1};
    ve[6]  = {32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    ve[7]  = {32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    ve[8]  = {32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    ve[9]  = {32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
    ve[10] = {32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
    for (int i = 0; i < 11; i++) begin
      doTransaction(vc[i], vx[i], vy[i], got);
      checks++;
      if (got !== ve[i]) begin
        errors++;
        $display("FAIL directed_%0d cmd=%0d: got %s, expected %s", i, vc[i], fmt(got), fmt(ve[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] special [5];
    logic [3:0]  c;
    logic [31:0] x, y;
    outT         got, exp;
    special = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    for (int i = 0; i < 50; i++) begin
      c = 4'($urandom_range(0, 15));
      x = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 4)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 4)] : $urandom;
      exp = model(c, x, y);
      doTransaction(c, x, y, got);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_%0d cmd=%0d a=%h b=%h: got %s, expected %s", i, c, x, y, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_mul();
    outT got, exp;
`ifdef ALU_SEQ_MUL_EN
    int   n;
    logic readySeen;
    @(negedge clk);
    in_valid = 1'b1; cmd = CMD_MUL; a = 32'h10000; b = 32'h10001;
    @(negedge clk);
    cmd = CMD_ADD; a = 32'h1; b = 32'h2;
    n = 1;
    readySeen = 1'b0;
    while (!out_valid && n < 100) begin
      if (in_ready) readySeen = 1'b1;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    got = sample(out_valid ? 8'(n) : 8'd0);
    exp = {32'h00010000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd33};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL mul_directed: got %s, expected %s", fmt(got), fmt(exp));
    end
    checks++;
    if (readySeen !== 1'b0) begin
      errors++;
      $display("FAIL mul_busy_ready: in_ready seen=%b during BUSY, expected 0", readySeen);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mul_no_queue: out_valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] x, y;
      x = (i == 0) ? 32'hFFFFFFFF : $urandom;
      y = (i == 0) ? 32'hFFFFFFFF : (i == 1) ? 32'h0 : $urandom;
      exp = model(CMD_MUL, x, y);
      doTransaction(CMD_MUL, x, y, got);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mul_random_%0d a=%h b=%h: got %s, expected %s", i, x, y, fmt(got), fmt(exp));
      end
    end
`else
    exp = {32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1};
    doTransaction(CMD_MUL, 32'h10000, 32'h10001, got);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL mul_disabled_illegal: got %s, expected %s", fmt(got), fmt(exp));
    end
`endif
  endtask

  task automatic test_back_to_back();
    outT exp, got;
    logic [31:0] x, y;
    x = $urandom;
    y = $urandom;
    exp = model(CMD_XOR, x, y);
    @(negedge clk);
    in_valid = 1'b1; cmd = CMD_XOR; a = x; b = y;
    @(negedge clk);
    cmd = CMD_SUB; a = $urandom; b = $urandom;
    got = sample(out_valid ? 8'd1 : 8'd0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL hold_first: got %s, expected %s", fmt(got), fmt(exp));
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      got = sample(out_valid ? 8'd1 : 8'd0);
      checks++;
      if (got !== exp || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle_%0d: got %s in_ready=%b, expected %s in_ready=0",
                 i, fmt(got), in_ready, fmt(exp));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_to_idle: out_valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
    end
    x = $urandom;
    y = $urandom;
    exp = model(CMD_OR, x, y);
    doTransaction(CMD_OR, x, y, got);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL accept_after_release: got %s, expected %s", fmt(got), fmt(exp));
    end
  endtask

  task automatic test_reset_mid_op();
    logic sawValid;
    @(negedge clk);
    in_valid = 1'b1;
`ifdef ALU_SEQ_MUL_EN
    cmd = CMD_MUL;
`else
    cmd = CMD_ADD;
`endif
    a = 32'hFFFF; b = 32'h3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, result, carryout, overflow, zero, err} !== '0) begin
      errors++;
      $display("FAIL reset_mid_op: in_ready=%b out_valid=%b %s, expected all zero",
               in_ready, out_valid, fmt(sample(8'd0)));
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready: in_ready=%b, expected 1", in_ready);
    end
    sawValid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    checks++;
    if (sawValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_aborts_op: out_valid seen=%b after reset, expected 0", sawValid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mul();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port cmd  input  4  operation code, per REQ-011.
REQ-007 SHALL have port a, b  input  WIDTH  operands, sampled at accept.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 SHALL have ports result  output  WIDTH, carryout/overflow/zero/err  output  1 each; all held stable while out_valid=1.

Function
REQ-011 cmd encoding SHALL be: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 OR, 7 NOR, 8 SLL, 9 SRL, 10 SRA, 11 MUL, 12-15 illegal.
REQ-012 Accept SHALL occur on the rising edge where in_valid=1 and in_ready=1; a, b, cmd are captured then and ignored afterwards.
REQ-013 FSM SHALL have states IDLE, BUSY, DONE; in_ready=1 only in IDLE with reset=0; one operation in flight at a time.
REQ-014 Transitions: IDLE->DONE on accept of cmd!=MUL; IDLE->BUSY on accept of MUL; BUSY->DONE after WIDTH iterations; DONE->IDLE on out_ready=1; otherwise hold.
REQ-015 out_valid SHALL be 1 exactly in DONE; non-MUL latency SHALL be 1 cycle (out_valid in cycle after accept); MUL latency SHALL be WIDTH+1 cycles.
REQ-016 ADD/SUB: two's-complement modulo 2^WIDTH; SUB = a + ~b + 1; carryout = adder carry out of MSB; overflow = signed overflow.
REQ-017 SLT: result = {WIDTH-1 zeros, (a-b)[MSB] XOR signed overflow}.
REQ-018 Logic ops: bitwise over full WIDTH; NAND/NOR are bitwise inverses of AND/OR.
REQ-019 Shifts: amount = b[log2(WIDTH)-1:0], upper b bits ignored; SRA replicates a[MSB]; amount 0 returns a.
REQ-020 MUL: unsigned shift-add, one partial product per BUSY cycle; result = low WIDTH bits of a*b; overflow = 1 iff any high product bit nonzero.
REQ-021 carryout SHALL be 0 for all ops except ADD/SUB; overflow SHALL be 0 except ADD/SUB/MUL.
REQ-022 zero SHALL equal (result == 0) for every op.
REQ-023 Illegal cmd: result 0, err=1, zero=1, other flags 0, latency 1; err=0 for all legal ops.
REQ-024 out_ready while out_valid=0 SHALL be ignored; in_valid outside IDLE SHALL be ignored (no queuing).

Reset
REQ-025 reset=1 at any edge SHALL force IDLE and clear result, all flags, out_valid to 0, aborting any BUSY/DONE operation with no output.
REQ-026 in_ready SHALL be 0 while reset=1 and 1 in the first cycle after reset deasserts.

Configuration
REQ-027 With ALU_SEQ_MUL_EN defined, MUL SHALL behave per REQ-020.
REQ-028 Without ALU_SEQ_MUL_EN, cmd 11 SHALL be treated as illegal per REQ-023, BUSY SHALL be unreachable, and no multiplier logic SHALL be present.

Structure
REQ-029 Shared package alu_seq_pkg SHALL hold the cmd encoding constants and the FSM state type.
REQ-030 Iterative multiplier SHALL be sub-module alu_seq_mul (start, done, a, b, product low/high), instantiated only under ALU_SEQ_MUL_EN.

Verification (WIDTH=32)
REQ-031 ADD a=0x7FFFFFFF, b=1 -> one cycle later out_valid=1, result=0x80000000, overflow=1, carryout=0, zero=0.
REQ-032 SUB a=5, b=5 -> result=0, zero=1, carryout=1, overflow=0; SLT a=0xFFFFFFFF, b=1 -> result=1.
REQ-033 SRA a=0x80000000, b=0x21 -> result=0xC0000000 (amount 1); SRL same -> 0x40000000.
REQ-034 MUL (MUL_EN) a=0x10000, b=0x10001 -> out_valid 33 cycles after accept, result=0x00010000, overflow=1; in_valid during BUSY ignored, in_ready=0.
REQ-035 out_ready=0 for 5 cycles after result -> result/flags stable, in_ready=0; out_ready=1 -> IDLE next cycle, new accept possible.
REQ-036 reset asserted mid-MUL -> next cycle IDLE, out_valid=0, result=0; cmd 13 -> err=1, result=0, zero=1.
